// File: rtl/systolic_mac_cell.sv
// systolic_mac_cell
//   Internal cell of an output-stationary systolic matrix-multiply array.
//   LANES independent signed MAC lanes share one v/s/en control set.
//   Operands and control tags are forwarded east/south with one cycle of
//   latency. Each lane accumulates x*w; a start tag closes the running dot
//   product, presents it on acc_out with a one-cycle acc_vld pulse, and seeds
//   the accumulator with the product that carried the start tag.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-low reset
//   en       advance enable; 0 freezes every register in the cell
//   v_in     input data valid
//   s_in     start tag (qualified by v_in)
//   x_in     west operands, lane i at [i*DATA_W +: DATA_W]
//   w_in     north operands, same packing
//   v_out    v_in delayed one cycle
//   s_out    (s_in & v_in) delayed one cycle
//   x_out    x_in delayed one cycle
//   w_out    w_in delayed one cycle
//   acc_out  completed dot product per lane, lane i at [i*ACC_W +: ACC_W]
//   acc_vld  one-cycle pulse when acc_out carries a new result
//   ovf      per-lane overflow flag for the result currently on acc_out

module systolic_mac_cell #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int LANES  = 1,
  parameter int SAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    v_in,
  input  logic                    s_in,
  input  logic [LANES*DATA_W-1:0] x_in,
  input  logic [LANES*DATA_W-1:0] w_in,
  output logic                    v_out,
  output logic                    s_out,
  output logic [LANES*DATA_W-1:0] x_out,
  output logic [LANES*DATA_W-1:0] w_out,
  output logic [LANES*ACC_W-1:0]  acc_out,
  output logic                    acc_vld,
  output logic [LANES-1:0]        ovf
);

  localparam int P_W   = 2 * DATA_W;
  // Sign-extension width from the product to the ACC_W+1 bit working sum.
  localparam int EXT_W = (ACC_W + 1 > P_W) ? (ACC_W + 1 - P_W) : 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < P_W) begin : g_bad_acc_w
    $error("systolic_mac_cell: ACC_W must be >= 2*DATA_W");
  end

  // Stage-1 tags double as the forwarded v/s outputs: both are the input
  // tags registered on the same enabled edge.
  logic v_st1;
  logic s_st1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_st1   <= 1'b0;
      s_st1   <= 1'b0;
      x_out   <= '0;
      w_out   <= '0;
      acc_vld <= 1'b0;
    end else if (en) begin
      v_st1   <= v_in;
      s_st1   <= s_in & v_in;
      x_out   <= x_in;
      w_out   <= w_in;
      acc_vld <= v_st1 & s_st1;
    end
  end

  assign v_out = v_st1;
  assign s_out = s_st1;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [P_W-1:0]   x_ext;
    logic signed [P_W-1:0]   w_ext;
    logic signed [P_W-1:0]   prod_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    ovf_q;
    logic signed [ACC_W-1:0] res_q;
    logic                    res_ovf_q;
    logic signed [ACC_W:0]   prod_sum_ext;
    logic signed [ACC_W:0]   sum;
    logic                    sum_ovf;
    logic signed [ACC_W-1:0] acc_next;

    assign x_ext = P_W'($signed(x_in[i*DATA_W +: DATA_W]));
    assign w_ext = P_W'($signed(w_in[i*DATA_W +: DATA_W]));

    // Stage 1: full-width product; it cannot overflow P_W bits.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        prod_q <= '0;
      end else if (en) begin
        prod_q <= x_ext * w_ext;
      end
    end

    // One guard bit above the accumulator exposes signed overflow as a
    // disagreement between the top two bits of the sum.
    always_comb begin
      prod_sum_ext = {{EXT_W{prod_q[P_W-1]}}, prod_q};
      sum          = {acc_q[ACC_W-1], acc_q} + prod_sum_ext;
      sum_ovf      = sum[ACC_W] ^ sum[ACC_W-1];
      acc_next     = sum[ACC_W-1:0];
      if ((SAT != 0) && sum_ovf) begin
        acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
    end

    // Stage 2: accumulate, or on a start tag hand the finished sum to the
    // output register and restart from the tagged product.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc_q     <= '0;
        ovf_q     <= 1'b0;
        res_q     <= '0;
        res_ovf_q <= 1'b0;
      end else if (en && v_st1) begin
        if (s_st1) begin
          res_q     <= acc_q;
          res_ovf_q <= ovf_q;
          acc_q     <= prod_sum_ext[ACC_W-1:0];
          ovf_q     <= 1'b0;
        end else begin
          acc_q <= acc_next;
          if (sum_ovf) begin
            ovf_q <= 1'b1;
          end
        end
      end
    end

    assign acc_out[i*ACC_W +: ACC_W] = res_q;
    assign ovf[i]                    = res_ovf_q;
  end

endmodule

// File: tb/tb_systolic_mac_cell.sv
// tb_systolic_mac_cell
//   Drives three cells in lockstep from shared stimulus:
//     a: defaults (1 lane, 40-bit accumulator, saturating)
//     b: 4 lanes, 32-bit accumulator, saturating
//     c: 4 lanes, 32-bit accumulator, wrapping
//   Expected outputs come from a transaction-level model: running sums kept
//   as 64-bit integers, with each closed result becoming visible one enabled
//   edge after the start tag that closed it was accepted.

module tb_systolic_mac_cell;

  logic clk;
  logic rst;
  logic en;
  logic v_in;
  logic s_in;
  logic [63:0] x_in;
  logic [63:0] w_in;

  logic        v_a, s_a, vld_a;
  logic [15:0] xo_a, wo_a;
  logic [39:0] acc_a;
  logic [0:0]  ovf_a;

  logic        v_b, s_b, vld_b;
  logic [63:0] xo_b, wo_b;
  logic [127:0] acc_b;
  logic [3:0]  ovf_b;

  logic        v_c, s_c, vld_c;
  logic [63:0] xo_c, wo_c;
  logic [127:0] acc_c;
  logic [3:0]  ovf_c;

  int n_vec;
  int n_err;

  systolic_mac_cell #(.DATA_W(16), .ACC_W(40), .LANES(1), .SAT(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .v_in(v_in), .s_in(s_in),
    .x_in(x_in[15:0]), .w_in(w_in[15:0]),
    .v_out(v_a), .s_out(s_a), .x_out(xo_a), .w_out(wo_a),
    .acc_out(acc_a), .acc_vld(vld_a), .ovf(ovf_a)
  );

  systolic_mac_cell #(.DATA_W(16), .ACC_W(32), .LANES(4), .SAT(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .v_in(v_in), .s_in(s_in),
    .x_in(x_in), .w_in(w_in),
    .v_out(v_b), .s_out(s_b), .x_out(xo_b), .w_out(wo_b),
    .acc_out(acc_b), .acc_vld(vld_b), .ovf(ovf_b)
  );

  systolic_mac_cell #(.DATA_W(16), .ACC_W(32), .LANES(4), .SAT(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .v_in(v_in), .s_in(s_in),
    .x_in(x_in), .w_in(w_in),
    .v_out(v_c), .s_out(s_c), .x_out(xo_c), .w_out(wo_c),
    .acc_out(acc_c), .acc_vld(vld_c), .ovf(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] e_x, e_w;
  bit          e_v, e_s, e_vld;
  longint      m_sum [3][4];
  bit          m_ovf [3][4];
  bit          pend_v;
  longint      pend_acc [3][4];
  bit          pend_ovf [3][4];
  longint      e_acc [3][4];
  bit          e_ovf [3][4];

  function automatic int accw(int c);
    return (c == 0) ? 40 : 32;
  endfunction

  function automatic bit sat_cfg(int c);
    return c != 2;
  endfunction

  function automatic int nlanes(int c);
    return (c == 0) ? 1 : 4;
  endfunction

  function automatic longint prod(logic [63:0] x, logic [63:0] w, int l);
    shortint xs;
    shortint ws;
    xs = x[l*16 +: 16];
    ws = w[l*16 +: 16];
    return longint'(xs) * longint'(ws);
  endfunction

  function automatic void acc_add(int c, int l, longint p);
    longint mx;
    longint mn;
    longint t;
    mx = (64'sd1 <<< (accw(c) - 1)) - 1;
    mn = -mx - 1;
    t  = m_sum[c][l] + p;
    if (t > mx || t < mn) begin
      m_ovf[c][l] = 1'b1;
      if (sat_cfg(c)) begin
        t = (t > mx) ? mx : mn;
      end else begin
        t = t & ((64'sd1 <<< accw(c)) - 1);
        if (t > mx) t = t - (64'sd1 <<< accw(c));
      end
    end
    m_sum[c][l] = t;
  endfunction

  function automatic void model_reset();
    e_x = '0; e_w = '0; e_v = 1'b0; e_s = 1'b0; e_vld = 1'b0; pend_v = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < 4; l++) begin
        m_sum[c][l] = 0; m_ovf[c][l] = 1'b0;
        pend_acc[c][l] = 0; pend_ovf[c][l] = 1'b0;
        e_acc[c][l] = 0; e_ovf[c][l] = 1'b0;
      end
    end
  endfunction

  // One accepted (enabled) edge with the given inputs.
  function automatic void model_step(bit v, bit s, logic [63:0] x, logic [63:0] w);
    e_vld = pend_v;
    if (pend_v) begin
      for (int c = 0; c < 3; c++) begin
        for (int l = 0; l < 4; l++) begin
          e_acc[c][l] = pend_acc[c][l];
          e_ovf[c][l] = pend_ovf[c][l];
        end
      end
    end
    pend_v = v & s;
    if (v) begin
      for (int c = 0; c < 3; c++) begin
        for (int l = 0; l < nlanes(c); l++) begin
          if (s) begin
            pend_acc[c][l] = m_sum[c][l];
            pend_ovf[c][l] = m_ovf[c][l];
            m_sum[c][l]    = prod(x, w, l);
            m_ovf[c][l]    = 1'b0;
          end else begin
            acc_add(c, l, prod(x, w, l));
          end
        end
      end
    end
    e_x = x; e_w = w; e_v = v; e_s = v & s;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] sx40(logic [39:0] v);
    return {{24{v[39]}}, v};
  endfunction

  task automatic check_all();
    chk("a_x_out", {48'd0, xo_a}, {48'd0, e_x[15:0]});
    chk("a_w_out", {48'd0, wo_a}, {48'd0, e_w[15:0]});
    chk("a_v_out", {63'd0, v_a}, {63'd0, e_v});
    chk("a_s_out", {63'd0, s_a}, {63'd0, e_s});
    chk("a_acc_vld", {63'd0, vld_a}, {63'd0, e_vld});
    chk("a_acc_out", sx40(acc_a), e_acc[0][0]);
    chk("a_ovf", {63'd0, ovf_a[0]}, {63'd0, e_ovf[0][0]});
    chk("b_x_out", xo_b, e_x);
    chk("b_w_out", wo_b, e_w);
    chk("b_v_out", {63'd0, v_b}, {63'd0, e_v});
    chk("b_s_out", {63'd0, s_b}, {63'd0, e_s});
    chk("b_acc_vld", {63'd0, vld_b}, {63'd0, e_vld});
    chk("c_x_out", xo_c, e_x);
    chk("c_w_out", wo_c, e_w);
    chk("c_v_out", {63'd0, v_c}, {63'd0, e_v});
    chk("c_s_out", {63'd0, s_c}, {63'd0, e_s});
    chk("c_acc_vld", {63'd0, vld_c}, {63'd0, e_vld});
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("b_acc_out%0d", l), sx32(acc_b[l*32 +: 32]), e_acc[1][l]);
      chk($sformatf("b_ovf%0d", l), {63'd0, ovf_b[l]}, {63'd0, e_ovf[1][l]});
      chk($sformatf("c_acc_out%0d", l), sx32(acc_c[l*32 +: 32]), e_acc[2][l]);
      chk($sformatf("c_ovf%0d", l), {63'd0, ovf_c[l]}, {63'd0, e_ovf[2][l]});
    end
  endtask

  // Apply one cycle of inputs, clock it, then check just after the edge.
  task automatic cyc(bit en_i, bit v_i, bit s_i, logic [63:0] x_i, logic [63:0] w_i);
    en = en_i; v_in = v_i; s_in = s_i; x_in = x_i; w_in = w_i;
    @(posedge clk);
    #1;
    if (en_i) model_step(v_i, s_i, x_i, w_i);
    check_all();
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #3 rst = 1'b1;
  endtask

  function automatic logic [63:0] rep(shortint v);
    logic [15:0] b;
    b = v;
    return {4{b}};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; v_in = 1'b0; s_in = 1'b0; x_in = '0; w_in = '0;
    model_reset();
    #1 rst = 1'b0;
    #1 check_all();
    @(posedge clk);
    #3 rst = 1'b1;

    // Reset mid-vector discards in-flight work; the next start emits 0.
    cyc(1, 1, 1, rep(3), rep(4));
    cyc(1, 1, 0, rep(5), rep(6));
    cyc(1, 1, 0, rep(-7), rep(8));
    do_reset();
    cyc(1, 1, 1, rep(1), rep(1));
    cyc(1, 0, 0, rep(0), rep(0));
    chk("rst_first_vld", {63'd0, vld_a}, 64'd1);
    chk("rst_first_acc", sx40(acc_a), 64'd0);

    // Forwarding, including s without v.
    cyc(1, 1, 0, rep(5), rep(-2));
    chk("fwd_x", {48'd0, xo_a}, 64'h5);
    chk("fwd_w", {48'd0, wo_a}, 64'hFFFE);
    cyc(1, 0, 1, rep(9), rep(9));
    chk("fwd_s_no_v", {63'd0, s_a}, 64'd0);

    // Dot product 2*3 + 4*(-5) + (-6)*7 = -56.
    cyc(1, 1, 1, rep(2), rep(3));
    cyc(1, 1, 0, rep(4), rep(-5));
    cyc(1, 1, 0, rep(-6), rep(7));
    cyc(1, 1, 1, rep(1), rep(1));
    chk("dot_not_yet", {63'd0, vld_a}, 64'd0);
    cyc(1, 0, 0, rep(0), rep(0));
    chk("dot_vld", {63'd0, vld_a}, 64'd1);
    chk("dot_acc", sx40(acc_a), -64'sd56);
    chk("dot_ovf", {63'd0, ovf_a[0]}, 64'd0);
    cyc(1, 0, 0, rep(0), rep(0));
    chk("dot_vld_pulse", {63'd0, vld_a}, 64'd0);

    // Four products of 32767*32767 = 0x3FFF0001 overflow a 32-bit sum.
    cyc(1, 1, 1, rep(32767), rep(32767));
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, rep(32767), rep(32767));
    cyc(1, 1, 1, rep(1), rep(1));
    cyc(1, 0, 0, rep(0), rep(0));
    chk("sat_acc", sx32(acc_b[31:0]), 64'sd2147483647);
    chk("sat_ovf", {63'd0, ovf_b[0]}, 64'd1);
    chk("wrap_acc", sx32(acc_c[31:0]), -64'sd262140);
    chk("wrap_ovf", {63'd0, ovf_c[0]}, 64'd1);
    chk("wide_acc", sx40(acc_a), 64'sd4294705156);
    chk("wide_ovf", {63'd0, ovf_a[0]}, 64'd0);
    cyc(1, 1, 1, rep(2), rep(2));
    cyc(1, 0, 0, rep(0), rep(0));
    chk("sat_next_acc", sx32(acc_b[31:0]), 64'sd1);
    chk("sat_next_ovf", {63'd0, ovf_b[0]}, 64'd0);

    // Stall and bubbles inside a vector: 3*3 + 2*5 = 19.
    cyc(1, 1, 1, rep(3), rep(3));
    for (int k = 0; k < 3; k++) cyc(0, 1, k[0], rep(shortint'($urandom)), rep(shortint'($urandom)));
    cyc(1, 0, 0, rep(100), rep(100));
    cyc(1, 1, 0, rep(2), rep(5));
    cyc(1, 0, 1, rep(50), rep(50));
    cyc(1, 1, 1, rep(0), rep(0));
    cyc(1, 0, 0, rep(0), rep(0));
    chk("stall_acc", sx40(acc_a), 64'sd19);
    cyc(0, 0, 0, rep(0), rep(0));
    chk("stall_vld_hold", {63'd0, vld_a}, 64'd1);
    cyc(1, 0, 0, rep(0), rep(0));
    chk("stall_vld_drop", {63'd0, vld_a}, 64'd0);

    // Randomized traffic with per-lane distinct operands.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] rx;
      logic [63:0] rw;
      rx = {$urandom, $urandom};
      rw = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        for (int l = 0; l < 4; l++) begin
          rx[l*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
          rw[l*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
        end
      end
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 4) == 0, rx, rw);
      if (i == 200) do_reset();
    end
    cyc(1, 1, 1, rep(0), rep(0));
    cyc(1, 0, 0, rep(0), rep(0));
    cyc(1, 0, 0, rep(0), rep(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
